// File: rtl/riscv_imm_decode_stage.sv
// riscv_imm_decode_stage: registered RV32I/RV64I immediate decode with a 2-entry output buffer.
// Rev 1.0
`default_nettype none

module riscv_imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter bit RV64W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [2:0] c_fmt_none = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_b    = 3'd3;
  localparam logic [2:0] c_fmt_u    = 3'd4;
  localparam logic [2:0] c_fmt_j    = 3'd5;
  localparam logic [2:0] c_fmt_z    = 3'd6;
  localparam bit         c_rv64w    = (XLEN == 64) && RV64W;
  localparam int         c_ew       = XLEN + 3 + 1 + 32 + XLEN;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("riscv_imm_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0]      w_opcode;
  logic [2:0]      w_fmt;
  logic            w_legal;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [c_ew-1:0] w_entry;

  assign w_opcode = in_inst[6:0];

  always_comb begin
    w_fmt   = c_fmt_none;
    w_legal = 1'b1;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: w_fmt = c_fmt_i;
      7'b0100011: w_fmt = c_fmt_s;
      7'b1100011: w_fmt = c_fmt_b;
      7'b0110111, 7'b0010111: w_fmt = c_fmt_u;
      7'b1101111: w_fmt = c_fmt_j;
      7'b0110011: w_fmt = c_fmt_none;
      7'b1110011: w_fmt = in_inst[14] ? c_fmt_z : c_fmt_none;
      7'b0011011: begin
        if (c_rv64w) w_fmt = c_fmt_i;
        else         w_legal = 1'b0;
      end
      7'b0111011: begin
        if (!c_rv64w) w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    if (in_inst[1:0] != 2'b11) w_legal = 1'b0;
    if (!w_legal) w_fmt = c_fmt_none;
  end

  // Every format places its sign bit at bit 31, so one signed widening serves all.
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      c_fmt_i: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      c_fmt_s: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      c_fmt_b: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
      c_fmt_u: w_imm32 = {in_inst[31:12], 12'd0};
      c_fmt_j: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
      c_fmt_z: w_imm32 = {27'd0, in_inst[19:15]};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign w_imm   = XLEN'($signed(w_imm32));
  assign w_entry = {w_imm, w_fmt, ~w_legal, in_inst, in_pc};

  logic [1:0]      r_count;
  logic            r_in_ready;
  logic [c_ew-1:0] r_head;
  logic [c_ew-1:0] r_tail;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_nxt;

  // Masking with rst keeps the port low during reset yet high on the first cycle after it.
  assign in_ready    = r_in_ready & ~rst;
  assign out_valid   = (r_count != 2'd0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (flush) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      // A full buffer never sees a push, since ready was already low.
      if (w_pop) begin
        if (r_count == 2'd2) r_head <= r_tail;
        else if (w_push)     r_head <= w_entry;
      end else if (w_push) begin
        if (r_count == 2'd0) r_head <= w_entry;
        else                 r_tail <= w_entry;
      end
    end
  end

  assign {out_imm, out_fmt, out_illegal, out_inst, out_pc} = out_valid ? r_head : '0;

endmodule

`default_nettype wire

// File: doc/riscv_imm_decode_stage.md
# riscv_imm_decode_stage

Registered immediate-decode stage for the RV32I/RV64I pipeline. It sits between fetch and the register-read/execute stage. It accepts instructions over a valid/ready handshake, extracts and sign-extends the immediate to XLEN bits, classifies the instruction format, and flags illegal encodings. A 2-entry output buffer decouples the stall path, so `in_ready` comes directly from a register. It extends the combinational immediate generator with XLEN parametrisation, CSR zimm handling, RV64 word opcodes, illegal detection and flush.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; any other value is a elaboration error.
- `RV64W`, 1: when XLEN=64, decode OP-IMM-32/OP-32 as legal; ignored when XLEN=32.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous pipeline flush, discards all buffered entries.
- `in_valid` in 1: input instruction valid.
- `in_ready` out 1: stage can accept (registered).
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: instruction address, passed through.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts head entry.
- `out_imm` out XLEN: sign/zero-extended immediate.
- `out_fmt` out 3: format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- `out_illegal` out 1: encoding not supported.
- `out_inst` out 32, `out_pc` out XLEN: passed-through copies.

## Operation
- Decode is combinational on `in_inst`. The result is written into the buffer on push (`in_valid && in_ready`).
- Immediates (sign-extend from inst[31] to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Z: zero-extend inst[19:15].
- Opcode map (inst[6:0]):
  - 0010011, 0000011, 1100111, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → NONE.
  - 1110011 with funct3[2]=1 → Z; with funct3[2]=0 → NONE.
  - 0011011 → I, and 0111011 → NONE, only when XLEN=64 && RV64W.
- Illegal: inst[1:0]≠2'b11 or any unmapped opcode. Then `out_illegal`=1, `out_fmt`=0, `out_imm`=0.
- When fmt is NONE, `out_imm`=0.
- Buffer: 2-entry FIFO with occupancy `count` ∈ {0,1,2}.
  - Head drives the outputs.
  - `out_valid` = (count≠0).
  - When `out_valid`=0, all data outputs are 0.
- Pop: `out_valid && out_ready`.
- Next `count` = count + push − pop.
  - Push and pop in the same cycle at count=1: the new entry becomes head, count stays 1.
- Head outputs stay stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst`=1 at an edge):
  - count=0.
  - `out_valid`=0; `out_imm`, `out_fmt`, `out_illegal`, `out_inst`, `out_pc` = 0.
  - `in_ready`=1 from the first cycle after reset.
  - `in_ready` is held 0 during any cycle in which `rst` is sampled high.
- Latency: an instruction pushed at edge N appears on the outputs after edge N, with `out_valid`=1 in cycle N+1, if count was 0 or was 1 with a pop.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- `in_ready` is registered: next `in_ready` = (next count < 2).
  - After count reaches 2, `in_ready` drops in the following cycle.
  - A push is never lost, because with a registered ready the worst case is exactly 2 entries.
- Flush:
  - count=0 at the next edge and `out_valid` deasserts.
  - A push or pop coincident with `flush` is discarded.
  - `in_ready`=1 in the next cycle.
- Priority is `rst` > `flush` > push/pop.
- Reset mid-stream discards all entries identically to flush and also zeros the data outputs.

## Test plan
- Decode sweep, XLEN=32, `out_ready`=1, each with one-cycle latency:
  - `0xFFF00093` → imm `0xFFFFFFFF`, fmt 1.
  - `0xFE112E23` → imm `0xFFFFFFFC`, fmt 2.
  - `0xFE000CE3` → imm `0xFFFFFFF8`, fmt 3.
  - `0x123452B7` → imm `0x12345000`, fmt 4.
  - `0xFFDFF06F` → imm `0xFFFFFFFC`, fmt 5.
  - `0x300FD073` → imm `0x0000001F`, fmt 6.
- Illegal: `0x00000013` with inst[1:0] forced to 00 (`0x00000010`) → illegal=1, fmt 0, imm 0.
  - With XLEN=32, `0x0010009B` → illegal=1.
  - With XLEN=64, `0x0010009B` → fmt 1, imm 1.
- XLEN=64: `0x800002B7` → imm `0xFFFFFFFF80000000`. `0xFFF00093` → imm all ones (64 bits).
- Backpressure: push 3 back-to-back with `out_ready`=0.
  - count reaches 2 and `in_ready` is 0 from the cycle after the second push.
  - Third is held off; outputs stay at first entry.
  - Release `out_ready` → entries emerge in order, none dropped or duplicated.
- Flush with count=2 plus a simultaneous push → next cycle `out_valid`=0, `in_ready`=1, and the pushed instruction never appears.
- Reset asserted with count=1 → all outputs 0 next cycle. After release, the first push emerges with correct imm.
